// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_checker
//  Description : Avalon-MM master that reads the system-ID slave (word 0 =
//                system ID, word 1 = build timestamp), compares both words
//                with expected constants and reports the result to the
//                boot / reset-release logic. A check runs once after reset
//                (AUTO_START) and again whenever start is pulsed while idle
//                or done. Every read is bounded by a waitrequest timeout.
//
//  Ports       : clk             - system clock, rising edge
//                reset           - asynchronous active-high reset
//                start           - one-cycle request to run a check
//                avm_address     - word address (0 = ID, 1 = timestamp)
//                avm_read        - read strobe
//                avm_waitrequest - slave stall
//                avm_readdata    - read data, valid on the completing cycle
//                id_value        - captured word 0
//                ts_value        - captured word 1
//                busy            - check in progress
//                done            - one-cycle pulse at the end of a check
//                pass            - sticky, both words matched, no timeout
//                id_ok           - sticky, word 0 matched
//                ts_ok           - sticky, word 1 matched
//                timeout         - sticky, last check aborted on a stall
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd1109322375,
    parameter logic [31:0] EXPECTED_TS    = 32'd1277243858,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_rd_id = 3'd1;
    localparam logic [2:0] c_st_rd_ts = 3'd2;
    localparam logic [2:0] c_st_cmp   = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // The counter holds the number of stalled cycles already seen, so the
    // read is abandoned on the stalled cycle that would bring it to the limit.
    localparam logic [15:0] c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_auto_pend;
    logic [15:0] r_cnt;
    logic        w_expire;

    logic        r_address;
    logic        r_read;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;

    // A completing read (waitrequest low) always wins over expiry.
    assign w_expire = avm_waitrequest && (r_cnt == c_tmo_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start || r_auto_pend) begin
                    w_next_state = c_st_rd_id;
                end
            end
            c_st_rd_id: begin
                if (!avm_waitrequest) begin
                    w_next_state = c_st_rd_ts;
                end else if (w_expire) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_rd_ts: begin
                if (!avm_waitrequest) begin
                    w_next_state = c_st_cmp;
                end else if (w_expire) begin
                    w_next_state = c_st_done;
                end
            end
            c_st_cmp: begin
                w_next_state = c_st_done;
            end
            c_st_done: begin
                if (start) begin
                    w_next_state = c_st_rd_id;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Auto-start request: armed by reset, consumed by the first clock
    // after reset deasserts so it fires exactly once per reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_auto_pend <= AUTO_START;
        end else begin
            r_auto_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Bus strobes, capture registers, timeout counter and result flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address  <= 1'b0;
            r_read     <= 1'b0;
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_cnt      <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_next_state == c_st_rd_id) begin
                        r_id_value <= 32'd0;
                        r_ts_value <= 32'd0;
                        r_pass     <= 1'b0;
                        r_id_ok    <= 1'b0;
                        r_ts_ok    <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_read     <= 1'b1;
                        r_address  <= 1'b0;
                        r_cnt      <= 16'd0;
                    end
                end
                c_st_rd_id: begin
                    if (!avm_waitrequest) begin
                        // Second read follows immediately, strobe stays high.
                        r_id_value <= avm_readdata;
                        r_address  <= 1'b1;
                        r_cnt      <= 16'd0;
                    end else if (w_expire) begin
                        r_read    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_st_rd_ts: begin
                    if (!avm_waitrequest) begin
                        r_ts_value <= avm_readdata;
                        r_read     <= 1'b0;
                        r_cnt      <= 16'd0;
                    end else if (w_expire) begin
                        r_read    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                c_st_cmp: begin
                    r_id_ok <= (r_id_value == EXPECTED_ID);
                    r_ts_ok <= (r_ts_value == EXPECTED_TS);
                    r_pass  <= (r_id_value == EXPECTED_ID) &&
                               (r_ts_value == EXPECTED_TS);
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign avm_address = r_address;
    assign avm_read    = r_read;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sysid_checker
//  Description : Self-checking bench for sysid_checker. Instance A
//                (AUTO_START=1, TIMEOUT_CYCLES=4) is driven by a slave model
//                with programmable per-word stall counts; instance B
//                (AUTO_START=0) exercises reset in the middle of a read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_checker;

    localparam logic [31:0] c_exp_id = 32'd1109322375;
    localparam logic [31:0] c_exp_ts = 32'd1277243858;
    localparam int          c_tmo_a  = 4;
    localparam int          c_stuck  = 1000;

    typedef struct packed {
        int          lat;
        int          e1;
        int          e2;
        logic [31:0] idv;
        logic [31:0] tsv;
        logic        idok;
        logic        tsok;
        logic        pass;
        logic        tmo;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- instance A ----------------
    logic        rst_a, start_a, addr_a, rd_a, wr_a;
    logic [31:0] rdata_a, idv_a, tsv_a;
    logic        busy_a, done_a, pass_a, idok_a, tsok_a, tmo_a;

    int          w0_cfg, w1_cfg, scnt_a;
    logic [31:0] id_word, ts_word;

    // Slave model: each read stalls for the programmed number of cycles.
    always @(posedge clk or posedge rst_a) begin
        if (rst_a)              scnt_a <= 0;
        else if (rd_a && wr_a)  scnt_a <= scnt_a + 1;
        else                    scnt_a <= 0;
    end
    assign wr_a    = rd_a && (scnt_a < (addr_a ? w1_cfg : w0_cfg));
    assign rdata_a = wr_a ? 32'h5A5A_A5A5 : (addr_a ? ts_word : id_word);

    sysid_checker #(
        .EXPECTED_ID(c_exp_id), .EXPECTED_TS(c_exp_ts),
        .TIMEOUT_CYCLES(c_tmo_a), .AUTO_START(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(rst_a), .start(start_a),
        .avm_address(addr_a), .avm_read(rd_a),
        .avm_waitrequest(wr_a), .avm_readdata(rdata_a),
        .id_value(idv_a), .ts_value(tsv_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .id_ok(idok_a), .ts_ok(tsok_a), .timeout(tmo_a)
    );

    // ---------------- instance B ----------------
    logic        rst_b, start_b, addr_b, rd_b, wr_b;
    logic [31:0] rdata_b, idv_b, tsv_b;
    logic        busy_b, done_b, pass_b, idok_b, tsok_b, tmo_b;

    assign rdata_b = addr_b ? c_exp_ts : c_exp_id;

    sysid_checker #(
        .EXPECTED_ID(c_exp_id), .EXPECTED_TS(c_exp_ts),
        .TIMEOUT_CYCLES(255), .AUTO_START(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .start(start_b),
        .avm_address(addr_b), .avm_read(rd_b),
        .avm_waitrequest(wr_b), .avm_readdata(rdata_b),
        .id_value(idv_b), .ts_value(tsv_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .id_ok(idok_b), .ts_ok(tsok_b), .timeout(tmo_b)
    );

    // ---------------- reference model ----------------
    // Cycle numbers count negedges after the edge that samples the kick.
    function automatic exp_t model(input int w0, input int w1,
                                   input logic [31:0] idw, input logic [31:0] tsw);
        exp_t r;
        r = '0;
        if (w0 >= c_tmo_a) begin
            r.e1 = c_tmo_a; r.e2 = c_tmo_a; r.lat = c_tmo_a + 1; r.tmo = 1'b1;
        end else begin
            r.e1  = 1 + w0;
            r.idv = idw;
            if (w1 >= c_tmo_a) begin
                r.e2 = r.e1 + c_tmo_a; r.lat = r.e2 + 1; r.tmo = 1'b1;
            end else begin
                r.e2   = r.e1 + 1 + w1;
                r.lat  = r.e2 + 2;
                r.tsv  = tsw;
                r.idok = (idw == c_exp_id);
                r.tsok = (tsw == c_exp_ts);
                r.pass = r.idok && r.tsok;
            end
        end
        return r;
    endfunction

    // ---------------- observation capture ----------------
    int          obs_lat;
    logic        obs_done_next, obs_busy;
    logic [31:0] obs_idv, obs_tsv;
    logic        obs_idok, obs_tsok, obs_pass, obs_tmo;
    logic        s1_busy, s1_pass, s1_idok, s1_tsok, s1_tmo;
    logic [31:0] s1_idv, s1_tsv;
    logic        tr_rd[0:255];
    logic        tr_addr[0:255];
    logic        tr_busy[0:255];

    // Kicks instance A (reset release or start pulse) from a negedge and
    // records what it does until one cycle after done; xs>0 pulses start
    // again at that cycle.
    task automatic run_one(input bit use_reset, input int xs);
        if (use_reset) rst_a = 1'b0;
        else           start_a = 1'b1;
        obs_lat = -1;
        obs_done_next = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            start_a    = (n == xs);
            tr_rd[n]   = rd_a;
            tr_addr[n] = addr_a;
            tr_busy[n] = busy_a;
            if (n == 1) begin
                s1_busy = busy_a; s1_pass = pass_a; s1_idok = idok_a;
                s1_tsok = tsok_a; s1_tmo = tmo_a; s1_idv = idv_a; s1_tsv = tsv_a;
            end
            if (obs_lat > 0) begin
                obs_done_next = done_a;
                break;
            end
            if (done_a === 1'b1) begin
                obs_lat = n;
                obs_idv = idv_a; obs_tsv = tsv_a; obs_idok = idok_a;
                obs_tsok = tsok_a; obs_pass = pass_a; obs_tmo = tmo_a;
                obs_busy = busy_a;
            end
        end
        start_a = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0; wr_b = 1'b0;
        w0_cfg = 0; w1_cfg = 0; id_word = c_exp_id; ts_word = c_exp_ts;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({addr_a, rd_a, busy_a, done_a, pass_a, idok_a, tsok_a, tmo_a} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_a_flags: got %b expected 00000000",
                     {addr_a, rd_a, busy_a, done_a, pass_a, idok_a, tsok_a, tmo_a});
        end
        n_checks++;
        if (idv_a !== 32'd0 || tsv_a !== 32'd0) begin
            n_err++; $display("FAIL reset_a_values: got %h/%h expected 0/0", idv_a, tsv_a);
        end
        n_checks++;
        if ({addr_b, rd_b, busy_b, done_b, pass_b, idok_b, tsok_b, tmo_b} !== 8'h00 ||
            idv_b !== 32'd0 || tsv_b !== 32'd0) begin
            n_err++; $display("FAIL reset_b: outputs not zero (busy=%b read=%b)", busy_b, rd_b);
        end
    endtask

    task automatic test_auto_start();
        run_one(1'b1, 0);
        n_checks++;
        if (obs_lat !== 4) begin
            n_err++; $display("FAIL auto_latency: got %0d expected 4", obs_lat);
        end
        n_checks++;
        if (tr_rd[1] !== 1'b1 || tr_addr[1] !== 1'b0 || tr_rd[2] !== 1'b1 || tr_addr[2] !== 1'b1) begin
            n_err++; $display("FAIL auto_addr_seq: got rd/addr %b%b %b%b expected 10 11",
                              tr_rd[1], tr_addr[1], tr_rd[2], tr_addr[2]);
        end
        n_checks++;
        if ({obs_pass, obs_idok, obs_tsok, obs_tmo, obs_done_next} !== 5'b11100) begin
            n_err++; $display("FAIL auto_flags: got %b expected 11100",
                              {obs_pass, obs_idok, obs_tsok, obs_tmo, obs_done_next});
        end
        n_checks++;
        if (obs_idv !== c_exp_id || obs_tsv !== c_exp_ts) begin
            n_err++; $display("FAIL auto_values: got %h/%h expected %h/%h",
                              obs_idv, obs_tsv, c_exp_id, c_exp_ts);
        end
    endtask

    task automatic test_ts_mismatch();
        ts_word = 32'd0;
        run_one(1'b0, 0);
        n_checks++;
        if (obs_lat !== 4 || {obs_idok, obs_tsok, obs_pass, obs_tmo} !== 4'b1000) begin
            n_err++; $display("FAIL ts_mismatch_flags: got lat %0d flags %b expected 4 1000",
                              obs_lat, {obs_idok, obs_tsok, obs_pass, obs_tmo});
        end
        n_checks++;
        if (obs_tsv !== 32'd0 || obs_idv !== c_exp_id) begin
            n_err++; $display("FAIL ts_mismatch_values: got %h/%h expected %h/0", obs_idv, obs_tsv, c_exp_id);
        end
        ts_word = c_exp_ts;
    endtask

    task automatic test_wait_states();
        exp_t ex;
        w0_cfg = 3; w1_cfg = 3;
        ex = model(3, 3, c_exp_id, c_exp_ts);
        run_one(1'b0, 0);
        n_checks++;
        if (obs_lat !== 10 || obs_pass !== 1'b1) begin
            n_err++; $display("FAIL wait_done: got lat %0d pass %b expected 10 1", obs_lat, obs_pass);
        end
        for (int n = 1; n < ex.lat; n++) begin
            n_checks++;
            if (tr_rd[n] !== (n <= ex.e2) || tr_addr[n] !== (n > ex.e1)) begin
                n_err++; $display("FAIL wait_strobe cycle %0d: got rd/addr %b%b expected %b%b",
                                  n, tr_rd[n], tr_addr[n], (n <= ex.e2), (n > ex.e1));
            end
        end
        w0_cfg = 0; w1_cfg = 0;
    endtask

    task automatic test_timeout();
        w0_cfg = c_stuck;
        run_one(1'b0, 0);
        n_checks++;
        if (obs_lat !== c_tmo_a + 1 || tr_rd[c_tmo_a] !== 1'b1 || tr_rd[c_tmo_a + 1] !== 1'b0) begin
            n_err++; $display("FAIL timeout_drop: got lat %0d rd@4 %b rd@5 %b expected 5 1 0",
                              obs_lat, tr_rd[c_tmo_a], tr_rd[c_tmo_a + 1]);
        end
        n_checks++;
        if ({obs_tmo, obs_pass, obs_idok, obs_tsok, obs_done_next} !== 5'b10000 || obs_idv !== 32'd0) begin
            n_err++; $display("FAIL timeout_flags: got %b id %h expected 10000 0",
                              {obs_tmo, obs_pass, obs_idok, obs_tsok, obs_done_next}, obs_idv);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_a !== 1'b0 || tmo_a !== 1'b1 || busy_a !== 1'b0 || rd_a !== 1'b0) begin
            n_err++; $display("FAIL timeout_hold: got done %b tmo %b busy %b rd %b expected 0 1 0 0",
                              done_a, tmo_a, busy_a, rd_a);
        end
        w0_cfg = 0;
    endtask

    task automatic test_start_while_busy();
        w1_cfg = 2;
        run_one(1'b0, 3);
        n_checks++;
        if (obs_lat !== 6 || obs_pass !== 1'b1 || obs_done_next !== 1'b0) begin
            n_err++; $display("FAIL busy_start_ignored: got lat %0d pass %b expected 6 1", obs_lat, obs_pass);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b1) begin
            n_err++; $display("FAIL busy_results_held: got busy %b done %b pass %b expected 0 0 1",
                              busy_a, done_a, pass_a);
        end
        w1_cfg = 0; ts_word = 32'h0000_0001;
        run_one(1'b0, 0);
        n_checks++;
        if ({s1_busy, s1_pass, s1_idok, s1_tsok, s1_tmo} !== 5'b10000 || s1_idv !== 32'd0) begin
            n_err++; $display("FAIL rerun_clear: got %b id %h expected 10000 0",
                              {s1_busy, s1_pass, s1_idok, s1_tsok, s1_tmo}, s1_idv);
        end
        n_checks++;
        if ({obs_pass, obs_idok, obs_tsok} !== 3'b010 || obs_lat !== 4) begin
            n_err++; $display("FAIL rerun_result: got %b lat %0d expected 010 4",
                              {obs_pass, obs_idok, obs_tsok}, obs_lat);
        end
        ts_word = c_exp_ts;
    endtask

    task automatic test_random();
        exp_t        ex;
        int          sel;
        logic [31:0] base;
        for (int i = 0; i < 14; i++) begin
            w0_cfg = (i == 0) ? c_tmo_a - 1 : int'($urandom_range(0, 5));
            w1_cfg = (i == 0) ? c_tmo_a     : int'($urandom_range(0, 5));
            for (int k = 0; k < 2; k++) begin
                base = (k == 0) ? c_exp_id : c_exp_ts;
                sel  = int'($urandom_range(0, 2));
                if (sel == 1) base = base ^ (32'd1 << $urandom_range(0, 31));
                if (sel == 2) base = $urandom;
                if (k == 0) id_word = base; else ts_word = base;
            end
            ex = model(w0_cfg, w1_cfg, id_word, ts_word);
            run_one(1'b0, 0);
            n_checks++;
            if (obs_lat !== ex.lat || obs_done_next !== 1'b0 || obs_busy !== 1'b0) begin
                n_err++; $display("FAIL rand%0d_timing: got lat %0d next %b busy %b expected %0d 0 0",
                                  i, obs_lat, obs_done_next, obs_busy, ex.lat);
            end
            n_checks++;
            if ({obs_idok, obs_tsok, obs_pass, obs_tmo} !== {ex.idok, ex.tsok, ex.pass, ex.tmo}) begin
                n_err++; $display("FAIL rand%0d_flags: got %b expected %b", i,
                                  {obs_idok, obs_tsok, obs_pass, obs_tmo}, {ex.idok, ex.tsok, ex.pass, ex.tmo});
            end
            n_checks++;
            if (obs_idv !== ex.idv || obs_tsv !== ex.tsv) begin
                n_err++; $display("FAIL rand%0d_values: got %h/%h expected %h/%h",
                                  i, obs_idv, obs_tsv, ex.idv, ex.tsv);
            end
            n_checks++;
            if ({s1_busy, s1_pass, s1_idok, s1_tsok, s1_tmo} !== 5'b10000 || s1_idv !== 32'd0 || s1_tsv !== 32'd0) begin
                n_err++; $display("FAIL rand%0d_entry: got %b expected 10000", i,
                                  {s1_busy, s1_pass, s1_idok, s1_tsok, s1_tmo});
            end
            for (int n = 1; n < ex.lat && n < 200; n++) begin
                n_checks++;
                if (tr_rd[n] !== (n <= ex.e2) || (n <= ex.e2 && tr_addr[n] !== (n > ex.e1)) ||
                    tr_busy[n] !== 1'b1) begin
                    n_err++; $display("FAIL rand%0d_cycle%0d: got rd/addr/busy %b%b%b expected %b%b1",
                                      i, n, tr_rd[n], tr_addr[n], tr_busy[n], (n <= ex.e2), (n > ex.e1));
                end
            end
        end
        w0_cfg = 0; w1_cfg = 0; id_word = c_exp_id; ts_word = c_exp_ts;
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        rst_b = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy_b !== 1'b0 || rd_b !== 1'b0) begin
            n_err++; $display("FAIL noauto_idle: got busy %b rd %b expected 0 0", busy_b, rd_b);
        end
        wr_b = 1'b1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rd_b !== 1'b1 || busy_b !== 1'b1 || addr_b !== 1'b0) begin
            n_err++; $display("FAIL midread_active: got rd %b busy %b addr %b expected 1 1 0", rd_b, busy_b, addr_b);
        end
        #2 rst_b = 1'b1;
        #1;
        n_checks++;
        if ({addr_b, rd_b, busy_b, done_b, pass_b, idok_b, tsok_b, tmo_b} !== 8'h00 ||
            idv_b !== 32'd0 || tsv_b !== 32'd0) begin
            n_err++; $display("FAIL midread_async_reset: got rd %b busy %b expected 0 0", rd_b, busy_b);
        end
        @(negedge clk);
        rst_b = 1'b0; wr_b = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (rd_b !== 1'b0 || busy_b !== 1'b0) begin
            n_err++; $display("FAIL midread_stays_idle: got rd %b busy %b expected 0 0", rd_b, busy_b);
        end
        start_b = 1'b1;
        seen = 1'b0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (done_b === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || pass_b !== 1'b1) begin
            n_err++; $display("FAIL midread_rerun: got done %b pass %b expected 1 1", seen, pass_b);
        end
    endtask

    initial begin
        test_reset();
        test_auto_start();
        test_ts_mismatch();
        test_wait_states();
        test_timeout();
        test_start_while_busy();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
